// File: rtl/delay_meter_pkg.sv
// Shared types and defaults for the delay meter.
// Holds the FSM state encoding and default parameters.
package delay_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT     = 1000;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/delay_meter_edge_sync.sv
// Multi-flop synchronizer with a trailing edge-detect flop.
// Both measured inputs use this, so their latency cancels.
module edge_sync
  import delay_meter_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic any_edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o    = sync_q[STAGES-1];
  assign rise_o     = sync_q[STAGES-1] & ~prev_q;
  assign any_edge_o = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/delay_meter.sv
// Measures clk cycles between a start rising edge and a stop edge.
// Result is held with a valid/ready handshake until consumed.
module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm_i,
  input  logic             expect_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNT_W-1:0] res_cnt_o,
  output logic             res_timeout_o,
  output logic             res_mismatch_o
);

  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

  logic start_lvl, start_rise, start_any;
  logic stop_lvl, stop_rise, stop_any;
  logic unused_sig;

  edge_sync #(.STAGES(SYNC_STAGES)) u_start (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_i        (start_i),
    .level_o    (start_lvl),
    .rise_o     (start_rise),
    .any_edge_o (start_any)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_stop (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_i        (stop_i),
    .level_o    (stop_lvl),
    .rise_o     (stop_rise),
    .any_edge_o (stop_any)
  );

  assign unused_sig = ^{start_lvl, start_any, stop_rise};

  state_e           state_q;
  logic             busy_q;
  logic             valid_q;
  logic             exp_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] res_cnt_q;
  logic             res_to_q;
  logic             res_mm_q;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      exp_q     <= 1'b0;
      cnt_q     <= '0;
      res_cnt_q <= '0;
      res_to_q  <= 1'b0;
      res_mm_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
            exp_q   <= expect_i;
            cnt_q   <= '0;
          end
        end
        ARMED: begin
          // Stop edges alone are ignored until a start edge arrives
          if (start_rise && stop_any) begin
            state_q   <= HOLD;
            valid_q   <= 1'b1;
            res_cnt_q <= '0;
            res_to_q  <= 1'b0;
            res_mm_q  <= stop_lvl ^ exp_q;
          end else if (start_rise) begin
            state_q <= COUNT;
            cnt_q   <= '0;
          end
        end
        COUNT: begin
          if (stop_any) begin
            state_q   <= HOLD;
            valid_q   <= 1'b1;
            res_cnt_q <= cnt_inc;
            res_to_q  <= 1'b0;
            res_mm_q  <= stop_lvl ^ exp_q;
          end else if (cnt_inc == TO_C) begin
            state_q   <= HOLD;
            valid_q   <= 1'b1;
            res_cnt_q <= TO_C;
            res_to_q  <= 1'b1;
            res_mm_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        HOLD: begin
          if (res_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign res_valid_o    = valid_q;
  assign res_cnt_o      = res_cnt_q;
  assign res_timeout_o  = res_to_q;
  assign res_mismatch_o = res_mm_q;

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter with TIMEOUT=20.
// Expected values are hand-computed per scenario.
module tb_delay_meter;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             arm_i;
  logic             expect_i;
  logic             start_i;
  logic             stop_i;
  logic             busy_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [CNT_W-1:0] res_cnt_o;
  logic             res_timeout_o;
  logic             res_mismatch_o;

  int n_cmp = 0;
  int n_err = 0;

  delay_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (20),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arm_i          (arm_i),
    .expect_i       (expect_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .busy_o         (busy_o),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_cnt_o      (res_cnt_o),
    .res_timeout_o  (res_timeout_o),
    .res_mismatch_o (res_mismatch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (res_valid_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, res_valid_o, 1);
  endtask

  task automatic arm(input logic e);
    arm_i    = 1'b1;
    expect_i = e;
    tick();
    arm_i    = 1'b0;
    expect_i = 1'b0;
  endtask

  task automatic handshake(input string tag);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk({tag, "_vld0"}, res_valid_o, 0);
    chk({tag, "_busy0"}, busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "bench timeout");
  end

  initial begin
    int pulses;
    rst_n       = 1'b0;
    arm_i       = 1'b0;
    expect_i    = 1'b0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    res_ready_i = 1'b0;
    ticks(3);
    chk("rst_busy", busy_o, 0);
    chk("rst_vld", res_valid_o, 0);
    chk("rst_cnt", res_cnt_o, 0);
    chk("rst_to", res_timeout_o, 0);
    chk("rst_mm", res_mismatch_o, 0);
    rst_n = 1'b1;
    ticks(2);

    // basic: stop rises 5 cycles after start, expect=1
    arm(1'b1);
    chk("t1_busy", busy_o, 1);
    start_i = 1'b1;
    ticks(5);
    stop_i = 1'b1;
    wait_valid("t1_wait", 12);
    chk("t1_cnt", res_cnt_o, 5);
    chk("t1_to", res_timeout_o, 0);
    chk("t1_mm", res_mismatch_o, 0);
    ticks(3);
    chk("t1_hold_vld", res_valid_o, 1);
    chk("t1_hold_cnt", res_cnt_o, 5);
    handshake("t1");
    start_i = 1'b0;
    stop_i  = 1'b0;
    ticks(5);

    // start and stop rise together
    arm(1'b1);
    start_i = 1'b1;
    stop_i  = 1'b1;
    wait_valid("t2_wait", 12);
    chk("t2_cnt", res_cnt_o, 0);
    chk("t2_to", res_timeout_o, 0);
    chk("t2_mm", res_mismatch_o, 0);
    handshake("t2");
    start_i = 1'b0;
    stop_i  = 1'b0;
    ticks(5);

    // timeout with no stop edge
    arm(1'b0);
    start_i = 1'b1;
    wait_valid("t3_wait", 40);
    chk("t3_cnt", res_cnt_o, 20);
    chk("t3_to", res_timeout_o, 1);
    chk("t3_mm", res_mismatch_o, 0);
    handshake("t3");
    start_i = 1'b0;
    stop_i  = 1'b1;
    ticks(5);

    // stop falls 3 cycles after start while expect=1
    arm(1'b1);
    start_i = 1'b1;
    ticks(3);
    stop_i = 1'b0;
    wait_valid("t4_wait", 12);
    chk("t4_cnt", res_cnt_o, 3);
    chk("t4_to", res_timeout_o, 0);
    chk("t4_mm", res_mismatch_o, 1);
    handshake("t4");
    start_i = 1'b0;
    ticks(5);

    // ready held low 10 cycles, stray arm pulses ignored
    arm(1'b1);
    start_i = 1'b1;
    ticks(2);
    stop_i = 1'b1;
    wait_valid("t5_wait", 12);
    chk("t5_cnt", res_cnt_o, 2);
    for (int i = 0; i < 10; i++) begin
      arm_i    = (i == 4);
      expect_i = 1'b0;
      tick();
      chk("t5_stab_vld", res_valid_o, 1);
      chk("t5_stab_cnt", res_cnt_o, 2);
      chk("t5_stab_mm", res_mismatch_o, 0);
    end
    arm_i       = 1'b1;
    res_ready_i = 1'b1;
    tick();
    arm_i       = 1'b0;
    res_ready_i = 1'b0;
    chk("t5_hs_vld", res_valid_o, 0);
    chk("t5_hs_busy", busy_o, 0);
    tick();
    chk("t5_arm_ign", busy_o, 0);
    start_i = 1'b0;
    stop_i  = 1'b0;
    ticks(5);

    // reset mid-COUNT discards the measurement
    arm(1'b0);
    start_i = 1'b1;
    ticks(6);
    chk("t6_pre_busy", busy_o, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_busy", busy_o, 0);
    chk("t6_vld", res_valid_o, 0);
    chk("t6_cnt", res_cnt_o, 0);
    chk("t6_to", res_timeout_o, 0);
    chk("t6_mm", res_mismatch_o, 0);
    stop_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid_o !== 1'b0) pulses++;
    end
    chk("t6_no_vld", pulses, 0);
    chk("t6_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
